// File: rtl/stepper_phase_sequencer_if.sv
// Run configuration, run control and coil-drive bundle of the stepper sequencer.
// master: drives cfg_*, start, stop, ext_step; slave: drives coils, busy, done, steps_left.
interface stepper_phase_sequencer_if #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16
);
    logic [1:0]       cfg_mode;
    logic             cfg_dir;
    logic [DIV_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_steps;
    logic             cfg_ext;
    logic             start;
    logic             stop;
    logic             ext_step;
    logic [3:0]       coils;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] steps_left;

    modport master (
        output cfg_mode, cfg_dir, cfg_div, cfg_steps, cfg_ext,
        output start, stop, ext_step,
        input  coils, busy, done, steps_left
    );

    modport slave (
        input  cfg_mode, cfg_dir, cfg_div, cfg_steps, cfg_ext,
        input  start, stop, ext_step,
        output coils, busy, done, steps_left
    );
endinterface

// File: rtl/stepper_phase_sequencer.sv
// Stepper coil phase sequencer: wave/full/half sequences, timer or external steps.
// Ports: clk, rst_n (async active-low), bus (slave: cfg_*, start, stop,
// ext_step in; coils, busy, done, steps_left out). Define STEPPER_HOLD_EN to
// keep the last coil pattern driven while idle.
module stepper_phase_sequencer #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16
) (
    input logic                       clk,
    input logic                       rst_n,
    stepper_phase_sequencer_if.slave  bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [0:0]       state;
    logic [2:0]       ph;
    logic [DIV_W-1:0] timer;
    logic             sync1;
    logic             sync2;
    logic             sync_prev;
    logic             half_q;
    logic             dir_q;
    logic [3:0]       coils_q;
    logic             done_q;
    logic [CNT_W-1:0] steps_left_q;

    logic [2:0] delta;
    logic [2:0] ph_next;
    logic [2:0] ph_start;
    logic       step_go;
    logic       last_step;

    function automatic logic [3:0] pattern(input logic [2:0] idx);
        logic [3:0] p;
        case (idx)
            3'd0:    p = 4'b0001;
            3'd1:    p = 4'b0011;
            3'd2:    p = 4'b0010;
            3'd3:    p = 4'b0110;
            3'd4:    p = 4'b0100;
            3'd5:    p = 4'b1100;
            3'd6:    p = 4'b1000;
            3'd7:    p = 4'b1001;
            default: p = 4'b0000;
        endcase
        return p;
    endfunction

    always_comb begin
        delta   = half_q ? 3'd1 : 3'd2;
        // 3-bit arithmetic gives the mod-8 wrap in both directions
        ph_next = dir_q ? ph + delta : ph - delta;
        // Wave runs on even indices, full-step on odd ones
        ph_start = ph;
        if (bus.cfg_mode == 2'b00) begin
            ph_start[0] = 1'b0;
        end else if (bus.cfg_mode == 2'b01) begin
            ph_start[0] = 1'b1;
        end
        step_go   = bus.cfg_ext ? (sync2 & ~sync_prev) : (timer == '0);
        last_step = (steps_left_q == CNT_ONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ph           <= '0;
            timer        <= '0;
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            sync_prev    <= 1'b0;
            half_q       <= 1'b0;
            dir_q        <= 1'b0;
            coils_q      <= '0;
            done_q       <= 1'b0;
            steps_left_q <= '0;
        end else begin
            sync1     <= bus.ext_step;
            sync2     <= sync1;
            sync_prev <= sync2;
            done_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state        <= RUN;
                        half_q       <= bus.cfg_mode[1];
                        dir_q        <= bus.cfg_dir;
                        ph           <= ph_start;
                        steps_left_q <= bus.cfg_steps;
                        timer        <= bus.cfg_div;
`ifndef STEPPER_HOLD_EN
                        coils_q      <= pattern(ph_start);
`endif
                    end else begin
`ifndef STEPPER_HOLD_EN
                        // Final-step pattern is shown for the done cycle, then released
                        coils_q <= '0;
`endif
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state <= IDLE;
`ifndef STEPPER_HOLD_EN
                        coils_q <= '0;
`endif
                    end else begin
                        timer <= (timer == '0) ? bus.cfg_div : timer - DIV_ONE;
                        if (step_go) begin
                            ph      <= ph_next;
                            coils_q <= pattern(ph_next);
                            if (steps_left_q != '0) begin
                                steps_left_q <= steps_left_q - CNT_ONE;
                            end
                            if (last_step) begin
                                done_q <= 1'b1;
                                state  <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.coils      = coils_q;
    assign bus.busy       = (state == RUN);
    assign bus.done       = done_q;
    assign bus.steps_left = steps_left_q;
endmodule
